// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
// Optional match counter is enabled by defining SEQ_DET_MATCH_COUNT_EN.
package seq_det_pkg;

    typedef enum logic [0:0] {
        ST_UNCFG,
        ST_RUN
    } det_state_e;

    localparam logic MODE_MEALY = 1'b0;
    localparam logic MODE_MOORE = 1'b1;

    // Ones in the low `len` bit positions; selects which history bits take part in the compare.
    function automatic logic [31:0] len_mask(input logic [31:0] len);
        if (len >= 32'd32) begin
            return '1;
        end
        return (32'd1 << len) - 32'd1;
    endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Configuration, serial input and status bundle of the pattern detector.
// match_count is present only when SEQ_DET_MATCH_COUNT_EN is defined.
interface seq_detector_param_if #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned CNT_W   = 16
);
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cfg_moore;
    logic               in_valid;
    logic               x;
    logic               z;
    logic               armed;
`ifdef SEQ_DET_MATCH_COUNT_EN
    logic [CNT_W-1:0]   match_count;
`else
    logic [CNT_W-1:0]   unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

    modport master (
`ifdef SEQ_DET_MATCH_COUNT_EN
        input  match_count,
`endif
        output cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_moore, in_valid, x,
        input  z, armed
    );

    modport slave (
`ifdef SEQ_DET_MATCH_COUNT_EN
        output match_count,
`endif
        input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_moore, in_valid, x,
        output z, armed
    );

endinterface

// File: rtl/seq_det_match_cnt.sv
// Saturating match counter; clear has priority over increment.
module seq_det_match_cnt #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o
);
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial bit-pattern detector (overlap/non-overlap, Mealy/Moore, stallable).
// Define SEQ_DET_MATCH_COUNT_EN to add the saturating match counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int unsigned        MAX_LEN     = 8,
    parameter int unsigned        LEN_W       = 4,
    parameter logic [MAX_LEN-1:0] PAT_DEFAULT = MAX_LEN'(8'b0110),
    parameter int unsigned        LEN_DEFAULT = 4,
    parameter int unsigned        CNT_W       = 16
) (
    input logic                 clk,
    input logic                 reset_n,
    seq_detector_param_if.slave bus_io
);
    localparam logic [LEN_W-1:0] MaxLenW = LEN_W'(MAX_LEN);

    det_state_e         state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d, hist_q, hist_d;
    logic [LEN_W-1:0]   len_q, len_d, fill_q, fill_d;
    logic               overlap_q, overlap_d, moore_q, moore_d, zreg_q, zreg_d;
    logic [LEN_W-1:0]   cfg_len_clamped;
    logic [MAX_LEN-1:0] window, mask;
    logic               len_ok, pat_eq, hit;

    assign cfg_len_clamped = (bus_io.cfg_len > MaxLenW) ? MaxLenW : bus_io.cfg_len;
    assign window          = {hist_q[MAX_LEN-2:0], bus_io.x};
    assign mask            = MAX_LEN'(len_mask(32'(len_q)));
    assign pat_eq          = ((window ^ pat_q) & mask) == '0;
    // Fill gate: enough bits since the last clear to form a whole pattern.
    assign len_ok          = ({1'b0, fill_q} + (LEN_W + 1)'(1)) >= {1'b0, len_q};
    assign hit = (state_q == ST_RUN) & bus_io.in_valid & ~bus_io.cfg_we & len_ok & pat_eq;

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        moore_d   = moore_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        zreg_d    = hit;
        if (bus_io.cfg_we) begin
            pat_d     = bus_io.cfg_pattern;
            len_d     = cfg_len_clamped;
            overlap_d = bus_io.cfg_overlap;
            moore_d   = bus_io.cfg_moore;
            hist_d    = '0;
            fill_d    = '0;
            state_d   = (cfg_len_clamped == '0) ? ST_UNCFG : ST_RUN;
        end else if ((state_q == ST_RUN) && bus_io.in_valid) begin
            hist_d = window;
            if (hit && !overlap_q) begin
                fill_d = '0;
            end else if (fill_q != MaxLenW) begin
                fill_d = fill_q + LEN_W'(1);
            end
        end
    end

    always_comb begin
        bus_io.z = 1'b0;
        if (!bus_io.cfg_we) begin
            bus_io.z = (moore_q == MODE_MOORE) ? zreg_q : hit;
        end
    end

    assign bus_io.armed = (state_q == ST_RUN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= (LEN_DEFAULT == 0) ? ST_UNCFG : ST_RUN;
            pat_q     <= PAT_DEFAULT;
            len_q     <= LEN_W'(LEN_DEFAULT);
            overlap_q <= 1'b1;
            moore_q   <= MODE_MEALY;
            hist_q    <= '0;
            fill_q    <= '0;
            zreg_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            moore_q   <= moore_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            zreg_q    <= zreg_d;
        end
    end

`ifdef SEQ_DET_MATCH_COUNT_EN
    seq_det_match_cnt #(
        .CNT_W(CNT_W)
    ) u_match_cnt (
        .clk    (clk),
        .reset_n(reset_n),
        .inc_i  (hit),
        .clr_i  (bus_io.cfg_we),
        .count_o(bus_io.match_count)
    );
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule
